mlx5_cmd_str_arb: RTL

Round-robin arbiter that shares a single `mlx5_command_str` HLS component between `NUM_REQ` requesters. It issues calls on the component's call interface and tracks in-flight calls with an in-order ID FIFO. It returns each 64-bit string-pointer result to the requester that issued the call, and applies backpressure to the component's return interface when the response port stalls.

---
 rtl/mlx5_cmd_str_arb_if.sv | 36 +++
 rtl/mlx5_cmd_str_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mlx5_cmd_str_arb_if.sv
// Requester, response and component call/return signals
// of the mlx5_command_str arbiter.
interface mlx5_cmd_str_arb_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_command;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [63:0]           rsp_data;
    logic                  cs_start;
    logic                  cs_busy;
    logic [31:0]           cs_command;
    logic                  cs_done;
    logic                  cs_stall;
    logic [63:0]           cs_returndata;
    logic                  err_underflow;

    modport master (
        output req_valid, req_command, rsp_ready,
        output cs_busy, cs_done, cs_returndata,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
        input  cs_start, cs_command, cs_stall, err_underflow
    );

    modport slave (
        input  req_valid, req_command, rsp_ready,
        input  cs_busy, cs_done, cs_returndata,
        output req_ready, rsp_valid, rsp_id, rsp_data,
        output cs_start, cs_command, cs_stall, err_underflow
    );
endinterface

// File: rtl/mlx5_cmd_str_arb.sv
// Round-robin sharing of one mlx5_command_str component between
// NUM_REQ callers, routing in-order results back by requester index.
module mlx5_cmd_str_arb #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    mlx5_cmd_str_arb_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int AW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] out_q, out_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [IW-1:0] fifo_q [MAX_OUT];
    logic          rsp_valid_q, rsp_valid_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic [63:0]   rsp_data_q, rsp_data_d;
    logic          err_q, err_d;

    logic [IW-1:0] grant;
    logic [IW:0]   idx;
    logic          found;
    logic          any_req;
    logic          start;
    logic          issue;
    logic          stall;
    logic          accept;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            if (!found && bus.req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                grant = idx[IW-1:0];
            end
        end
    end

    assign any_req = |bus.req_valid;
    assign start   = any_req & (out_q < CW'(MAX_OUT));
    assign issue   = start & ~bus.cs_busy;
    assign stall   = rsp_valid_q & ~bus.rsp_ready;
    assign accept  = bus.cs_done & ~stall;
    assign pop     = accept & (out_q != '0);

    assign bus.cs_start   = start;
    assign bus.cs_stall   = stall;
    assign bus.cs_command = any_req ?
        bus.req_command[{grant, 5'd0} +: 32] : '0;
    assign bus.req_ready  = issue ?
        (NUM_REQ'(1) << grant) : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_d       = out_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        err_d       = err_q;
        if (issue) begin
            wr_d     = ptr_inc(wr_q);
            rr_ptr_d = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (issue && !pop) begin
            out_d = out_q + 1'b1;
        end else if (pop && !issue) begin
            out_d = out_q - 1'b1;
        end
        // A return with nothing in flight is still delivered, tagged 0.
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pop ? fifo_q[rd_q] : '0;
            rsp_data_d  = bus.cs_returndata;
            err_d       = err_q | ~pop;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            out_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_q       <= out_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (issue) begin
            fifo_q[wr_q] <= grant;
        end
    end

    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.err_underflow = err_q;
endmodule
